regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS writeback stage, successor to the single-write/dual-read GPR. Supports configurable data width, register count, read-port count and write-port count. Includes a per-register pending-write scoreboard so decode can detect hazards. Register 0 reads as zero; the stack-pointer register resets to a configurable value.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count, power of two ≥ 8; AW = $clog2(NUM_REGS)
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports (0 = writeback, 1 = late/mult-div port)
- SP_IDX, 29, stack-pointer register index
- SP_INIT, 32'h0000_03FF, SP reset value
- DBG_IDX, 5, register mirrored on dbg_out
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  addressed register has a pending write
- we  in  NUM_WR  write enables
- wa  in  NUM_WR*AW  write addresses
- wd  in  NUM_WR*DATA_W  write data
- iss_valid  in  1  decode issues an instruction with destination iss_addr
- iss_addr  in  AW  destination register of issuing instruction
- iss_ready  out  1  issue accepted this cycle
- dbg_out  out  DATA_W  current value of register DBG_IDX

## Operation
- Storage: registers 1..NUM_REGS-1; address 0 always reads 0, writes to 0 are dropped, 0 is never pending.
- Reset: all registers 0 except SP_IDX = SP_INIT; all pending bits 0. Consequently rd_busy = 0, iss_ready = 1, dbg_out = 0, and rd_data = 0 (SP_INIT when addressing SP_IDX).
- Write: on each edge, every port with we=1 and wa≠0 updates its register. Same-address conflict: highest-numbered port wins.
- Scoreboard: one pending bit per register.
  - Issue accepted (iss_valid & iss_ready) with iss_addr≠0 sets pending[iss_addr].
  - Any write to register r clears pending[r].
  - Set and clear of the same register in the same cycle: set wins, since the new producer is younger.
- iss_ready = !pending[iss_addr] | (clear of iss_addr this cycle) | iss_addr==0. Issue to a still-pending destination stalls (WAW).
- rd_busy[p] = pending[rd_addr[p]] and not cleared this cycle (bypass build only; see Configuration).
- Reset mid-operation: asynchronously clears all state immediately; any in-flight write or issue on that edge is lost.

## Timing
- Read latency: combinational, 0 cycles from rd_addr.
- Write-to-read: new data visible on rd_data in the cycle after the write edge; same cycle when bypass is enabled.
- Pending set visible on rd_busy and iss_ready the cycle after the accepted issue.
- Pending clear: visible the cycle after the write edge without bypass; same cycle with bypass.
- dbg_out reflects the register contents (no bypass), 1 cycle after the write.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read ports forward matching wd (wa==rd_addr, ≠0, highest port wins) combinationally in the write cycle.
  - rd_busy and iss_ready treat a same-cycle clear as already cleared.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored contents only.
  - rd_busy and iss_ready use registered pending bits only (stall one cycle longer).

## Structure
- Package regfile_pkg holds:
  - constants DEF_DATA_W, DEF_NUM_REGS, DEF_SP_IDX, DEF_SP_INIT, DEF_DBG_IDX
  - function for AW
  - typedef for write-request struct {we, wa, wd}
- One sub-module, regfile_scoreboard, holds the pending-bit vector plus the iss_ready and rd_busy logic.
- Storage, write arbitration and bypass muxes live in the top level.

## Test plan
- Reset then read all addresses → 0 everywhere except r29 = 0x3FF; dbg_out = 0; iss_ready = 1.
- Write r5 = 0xDEADBEEF via port 0 → dbg_out = 0xDEADBEEF next cycle; write r0 = 0x1234 → r0 still reads 0.
- Same-edge write r7: port0 = 0x11, port1 = 0x22 → r7 reads 0x22; with bypass, rd_data = 0x22 in the write cycle itself.
- Issue r8 → rd_busy = 1 when reading r8 next cycle; second issue to r8 → iss_ready = 0. Write r8 → busy clears (same cycle with bypass, next cycle without).
- Issue r9 and write r9 on the same edge → pending[r9] remains set and rd_busy = 1 afterwards.
- Assert rst mid-stream with r3 pending and r3 = 0x55 → immediately r3 reads 0, pending cleared, r29 = 0x3FF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, helpers and types for the multi-port GPR file.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 2;
    localparam int DEF_SP_IDX   = 29;
    localparam logic [DEF_DATA_W-1:0] DEF_SP_INIT = 32'h0000_03FF;
    localparam int DEF_DBG_IDX  = 5;

    // Register address width for a given register count.
    function automatic int regfile_aw(input int num_regs);
        return $clog2(num_regs);
    endfunction

    localparam int DEF_AW = regfile_aw(DEF_NUM_REGS);

    // One write-port request at the default geometry.
    typedef struct packed {
        logic                  we;
        logic [DEF_AW-1:0]     wa;
        logic [DEF_DATA_W-1:0] wd;
    } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, drives iss_ready and rd_busy.
// Latency: set/clear land on the next edge; with REGFILE_BYPASS_EN a same-cycle clear is seen at once.
// Backpressure: iss_ready low stalls an issue whose destination is still pending (WAW).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int AW       = regfile_aw(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REGS-1:0]  clr_i,
    input  logic                 iss_valid_i,
    input  logic [AW-1:0]        iss_addr_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic                 iss_ready_o,
    output logic [NUM_RD-1:0]    rd_busy_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] set_vec;
    logic                iss_nz;

    assign iss_nz = (iss_addr_i != '0);

    // Issue is accepted unless the destination still has an outstanding producer.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        iss_ready_o = !pend_q[iss_addr_i] || clr_i[iss_addr_i] || !iss_nz;
`else
        iss_ready_o = !pend_q[iss_addr_i] || !iss_nz;
`endif
    end

    // Next pending state: writes clear, an accepted issue sets; the set wins because its producer is younger.
    always_comb begin
        set_vec = '0;
        if (iss_valid_i && iss_ready_o && iss_nz) begin
            set_vec[iss_addr_i] = 1'b1;
        end
        pend_d    = (pend_q & ~clr_i) | set_vec;
        pend_d[0] = 1'b0;
    end

    // Pending bits, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
        logic [AW-1:0] ra;
        assign ra = rd_addr_i[p*AW +: AW];
        // Busy flag for read port p.
        always_comb begin
`ifdef REGFILE_BYPASS_EN
            rd_busy_o[p] = pend_q[ra] && !clr_i[ra];
`else
            rd_busy_o[p] = pend_q[ra];
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS GPR file with r0 hard-wired to zero, SP reset value and pending-write scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle on rd_data with REGFILE_BYPASS_EN).
// Backpressure: iss_ready deasserts while the issuing destination has a pending write.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter int                NUM_RD   = DEF_NUM_RD,
    parameter int                NUM_WR   = DEF_NUM_WR,
    parameter int                SP_IDX   = DEF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(DEF_SP_INIT),
    parameter int                DBG_IDX  = DEF_DBG_IDX,
    parameter int                AW       = regfile_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*AW-1:0]     wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    output logic                     iss_ready,
    output logic [DATA_W-1:0]        dbg_out
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;

    logic                wr_en   [NUM_WR];
    logic [AW-1:0]       wr_addr [NUM_WR];
    logic [DATA_W-1:0]   wr_data [NUM_WR];

    // Unpack write ports; writes to r0 are dropped here so nothing downstream sees them.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_addr[w] = wa[w*AW +: AW];
            wr_data[w] = wd[w*DATA_W +: DATA_W];
            wr_en[w]   = we[w] && (wa[w*AW +: AW] != '0);
        end
    end

    // Write arbitration: ports applied in order so the highest-numbered port wins a shared address.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                regs_d[wr_addr[w]] = wr_data[w];
                wr_hit[wr_addr[w]] = 1'b1;
            end
        end
    end

    // Register storage; r0 resets to zero and is never written, SP starts at SP_INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] val;
        assign ra = rd_addr[p*AW +: AW];
        // Read mux for port p, optionally forwarding a same-cycle write (highest port wins).
        always_comb begin
            val = (ra == '0) ? '0 : regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w] == ra)) begin
                    val = wr_data[w];
                end
            end
`endif
        end
        assign rd_data[p*DATA_W +: DATA_W] = val;
    end

    assign dbg_out = regs_q[DBG_IDX];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (wr_hit),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .rd_addr_i   (rd_addr),
        .iss_ready_o (iss_ready),
        .rd_busy_o   (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model of registers and pending bits feeds an expectation queue.
// Latency: one expectation per clock, compared mid low-phase.
// Backpressure: model decides issue acceptance from its own pending state.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int AW = DEF_AW;
    localparam int DW = DEF_DATA_W;
    localparam int NR = DEF_NUM_REGS;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic [1:0]      we = '0;
    logic [2*AW-1:0] wa = '0;
    logic [2*DW-1:0] wd = '0;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_addr = '0;
    logic            iss_ready;
    logic [DW-1:0]   dbg_out;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .dbg_out   (dbg_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0][AW-1:0] ra;
        logic [1:0][DW-1:0] rd;
        logic [1:0]         busy;
        logic               rdy;
        logic [DW-1:0]      dbg;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem  [NR];
    logic          m_pend [NR];
    int            errors = 0;
    int            checks = 0;

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_mem[DEF_SP_IDX] = DEF_SP_INIT;
    endfunction

    function automatic wr_req_t mk_wr(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req_t r;
        r.we = en;
        r.wa = a;
        r.wd = d;
        return r;
    endfunction

    // Expected outputs for the current inputs, from the architectural state of the model.
    task automatic push_exp(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                            input wr_req_t w0, input wr_req_t w1,
                            input logic [AW-1:0] ia, output logic rdy);
        exp_t          e;
        wr_req_t       ws [2];
        logic [AW-1:0] ra [2];
        logic [DW-1:0] v;
        logic          hit;
        logic          hit_ia;
        ws[0] = w0; ws[1] = w1;
        ra[0] = r0; ra[1] = r1;
        hit_ia = 1'b0;
        for (int w = 0; w < 2; w++)
            if (ws[w].we && ws[w].wa == ia && ia != 0) hit_ia = 1'b1;
        for (int p = 0; p < 2; p++) begin
            v   = (ra[p] == 0) ? '0 : m_mem[ra[p]];
            hit = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (ws[w].we && ws[w].wa != 0 && ws[w].wa == ra[p]) begin
                    hit = 1'b1;
                    if (BYP) v = ws[w].wd;
                end
            end
            e.ra[p]   = ra[p];
            e.rd[p]   = v;
            e.busy[p] = m_pend[ra[p]] && !(BYP && hit);
        end
        rdy   = (ia == 0) || !m_pend[ia] || (BYP && hit_ia);
        e.rdy = rdy;
        e.dbg = m_mem[DEF_DBG_IDX];
        exp_q.push_back(e);
    endtask

    // Architectural effect of one clock edge: writes in port order, then the accepted issue.
    task automatic model_update(input wr_req_t w0, input wr_req_t w1,
                                input logic iv, input logic [AW-1:0] ia, input logic rdy);
        wr_req_t ws [2];
        ws[0] = w0; ws[1] = w1;
        for (int w = 0; w < 2; w++) begin
            if (ws[w].we && ws[w].wa != 0) begin
                m_mem[ws[w].wa]  = ws[w].wd;
                m_pend[ws[w].wa] = 1'b0;
            end
        end
        if (iv && rdy && ia != 0) m_pend[ia] = 1'b1;
    endtask

    // One clock of stimulus: drive after the falling edge, post expectation, advance model on the rising edge.
    task automatic cyc(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input wr_req_t w0, input wr_req_t w1,
                       input logic iv, input logic [AW-1:0] ia, input logic rs);
        logic rdy;
        @(negedge clk);
        rst = rs;
        if (rs) m_reset();
        rd_addr   = {r1, r0};
        we        = {w1.we, w0.we};
        wa        = {w1.wa, w0.wa};
        wd        = {w1.wd, w0.wd};
        iss_valid = iv;
        iss_addr  = ia;
        #1;
        push_exp(r0, r1, w0, w1, ia, rdy);
        @(posedge clk);
        if (!rs) model_update(w0, w1, iv, ia, rdy);
    endtask

    task automatic chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=%h want=%h @%0t", name, a, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest outstanding expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rd_data%0d", p), e.ra[p], rd_data[p*DW +: DW], e.rd[p]);
                    chk($sformatf("rd_busy%0d", p), e.ra[p], DW'(rd_busy[p]), DW'(e.busy[p]));
                end
                chk("iss_ready", iss_addr, DW'(iss_ready), DW'(e.rdy));
                chk("dbg_out", AW'(DEF_DBG_IDX), dbg_out, e.dbg);
            end
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
        return AW'($urandom_range(0, 11));
    endfunction

    initial begin
        wr_req_t nw;
        wr_req_t w0, w1;
        logic    rs;
        nw = mk_wr(1'b0, '0, '0);
        m_reset();
        #12;

        // Reset contents: sweep every address.
        for (int i = 0; i < NR; i += 2)
            cyc(AW'(i), AW'(i + 1), nw, nw, 1'b0, '0, 1'b0);

        // r5 write, observed on dbg_out; r0 write dropped.
        cyc(5'd5, 5'd0, mk_wr(1'b1, 5'd5, 32'hDEADBEEF), nw, 1'b0, '0, 1'b0);
        cyc(5'd5, 5'd0, mk_wr(1'b1, 5'd0, 32'h0000_1234), nw, 1'b0, '0, 1'b0);
        cyc(5'd0, 5'd5, nw, nw, 1'b0, '0, 1'b0);

        // Same-edge conflict on r7.
        cyc(5'd7, 5'd6, mk_wr(1'b1, 5'd7, 32'h11), mk_wr(1'b1, 5'd7, 32'h22), 1'b0, '0, 1'b0);
        cyc(5'd7, 5'd7, nw, nw, 1'b0, '0, 1'b0);

        // Issue r8, WAW stall, then clear by a write.
        cyc(5'd8, 5'd1, nw, nw, 1'b1, 5'd8, 1'b0);
        cyc(5'd8, 5'd1, nw, nw, 1'b1, 5'd8, 1'b0);
        cyc(5'd8, 5'd1, nw, mk_wr(1'b1, 5'd8, 32'hCAFE_0008), 1'b1, 5'd8, 1'b0);
        cyc(5'd8, 5'd1, nw, nw, 1'b0, 5'd8, 1'b0);
        cyc(5'd8, 5'd1, mk_wr(1'b1, 5'd8, 32'h8888), nw, 1'b0, 5'd8, 1'b0);
        cyc(5'd8, 5'd1, nw, nw, 1'b0, '0, 1'b0);

        // Issue and write r9 on the same edge: pending survives.
        cyc(5'd9, 5'd2, mk_wr(1'b1, 5'd9, 32'h99), nw, 1'b1, 5'd9, 1'b0);
        cyc(5'd9, 5'd2, nw, nw, 1'b0, 5'd9, 1'b0);
        cyc(5'd9, 5'd2, mk_wr(1'b1, 5'd9, 32'h999), nw, 1'b0, '0, 1'b0);

        // Reset with r3 pending and holding 0x55; the issue in the reset cycle is lost.
        cyc(5'd3, 5'd29, mk_wr(1'b1, 5'd3, 32'h55), nw, 1'b0, '0, 1'b0);
        cyc(5'd3, 5'd29, nw, nw, 1'b1, 5'd3, 1'b0);
        cyc(5'd3, 5'd29, nw, nw, 1'b0, 5'd3, 1'b0);
        cyc(5'd3, 5'd29, nw, nw, 1'b1, 5'd3, 1'b1);
        cyc(5'd3, 5'd29, nw, nw, 1'b0, 5'd3, 1'b0);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 149) == 0);
            w0 = mk_wr(!rs && $urandom_range(0, 1) == 1, rnd_addr(), DW'($urandom));
            w1 = mk_wr(!rs && $urandom_range(0, 2) == 0, rnd_addr(), DW'($urandom));
            cyc(rnd_addr(), rnd_addr(), w0, w1, $urandom_range(0, 1) == 1, rnd_addr(), rs);
        end
        cyc('0, '0, nw, nw, 1'b0, '0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
